// File: rtl/adc_ctrl_pkg.sv
// Shared types and default widths for the ADC receive-window capture path.
package adc_ctrl_pkg;

  localparam int ADC_DATA_W = 10;
  localparam int ADC_LEN_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    BLANK,
    CAPTURE,
    DRAIN
  } capture_state_t;

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Captured-sample stream from adc_capture_ctrl to the downstream buffer/DSP.
interface adc_capture_ctrl_if import adc_ctrl_pkg::*; #(
  parameter int DATA_W = ADC_DATA_W
);

  // A beat transfers on a SYS_CLK edge where OUT_VALID and OUT_READY are both
  // high. Once raised, OUT_VALID, OUT_DATA and OUT_LAST hold until that edge;
  // OUT_READY may change freely and OUT_LAST is meaningful only with OUT_VALID.
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_LAST;
  logic              OUT_READY;

  modport master (
    output OUT_DATA,
    output OUT_VALID,
    output OUT_LAST,
    input  OUT_READY
  );

  modport slave (
    input  OUT_DATA,
    input  OUT_VALID,
    input  OUT_LAST,
    output OUT_READY
  );

endinterface

// File: rtl/adc_stream_reg.sv
// Single-entry valid/ready holding register; reports kept samples it had to drop.
module adc_stream_reg import adc_ctrl_pkg::*; #(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              SYS_CLK,
  input  logic              RESET,
  input  logic              flush,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              drop,
  output logic              last_accept,
  adc_capture_ctrl_if.master out_if
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              last_q;
  logic              xfer;

  assign xfer        = valid_q && out_if.OUT_READY;
  // A load is lost only when the entry is occupied and not leaving this cycle.
  assign drop        = load && valid_q && !out_if.OUT_READY;
  assign last_accept = xfer && last_q;

  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load && (!valid_q || out_if.OUT_READY)) begin
      data_q  <= load_data;
      valid_q <= 1'b1;
      last_q  <= load_last;
    end else if (xfer) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign out_if.OUT_DATA  = data_q;
  assign out_if.OUT_VALID = valid_q;
  assign out_if.OUT_LAST  = last_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Receive-window sequencer: ADC warm-up discard, blanking skip, decimated
// capture of a fixed sample count onto a valid/ready stream with LAST.
module adc_capture_ctrl import adc_ctrl_pkg::*; #(
  parameter int DATA_W         = ADC_DATA_W,
  parameter int LEN_W          = ADC_LEN_W,
  parameter int DECIM_W        = 4,
  parameter int WARMUP_SAMPLES = 4
) (
  input  logic               SYS_CLK,
  input  logic               RESET,
  input  logic               CMD_START,
  input  logic               CMD_ABORT,
  input  logic [LEN_W-1:0]   CFG_DELAY,
  input  logic [LEN_W-1:0]   CFG_LENGTH,
  input  logic [DECIM_W-1:0] CFG_DECIM,
  input  logic [DATA_W-1:0]  APP_DATA,
  input  logic               APP_DATA_VALID,
  output logic               ADC_EN,
  adc_capture_ctrl_if.master out_if,
  output logic               BUSY,
  output logic               DONE,
  output logic               OVERFLOW,
  output capture_state_t     DBG_STATE
);

  capture_state_t     state_q;
  logic [LEN_W-1:0]   delay_q;
  logic [LEN_W-1:0]   remain_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] phase_q;
  logic               adc_en_q;
  logic               done_q;
  logic               ovf_q;

  logic abort_hit;
  logic keep;
  logic keep_last;
  logic drop;
  logic last_accept;

  assign abort_hit = CMD_ABORT && (state_q != IDLE);
  assign keep      = (state_q == CAPTURE) && APP_DATA_VALID &&
                     (phase_q == '0) && !abort_hit;
  assign keep_last = keep && (remain_q == LEN_W'(1));

  adc_stream_reg #(.DATA_W(DATA_W)) u_stream (
    .SYS_CLK     (SYS_CLK),
    .RESET       (RESET),
    .flush       (abort_hit),
    .load        (keep),
    .load_data   (APP_DATA),
    .load_last   (keep_last),
    .drop        (drop),
    .last_accept (last_accept),
    .out_if      (out_if)
  );

  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      delay_q  <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      decim_q  <= '0;
      phase_q  <= '0;
      adc_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (drop) ovf_q <= 1'b1;

      if (abort_hit) begin
        state_q  <= IDLE;
        adc_en_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (CMD_START) begin
              delay_q  <= CFG_DELAY;
              remain_q <= CFG_LENGTH;
              decim_q  <= CFG_DECIM;
              cnt_q    <= '0;
              ovf_q    <= 1'b0;
              if (CFG_LENGTH == '0) begin
                done_q <= 1'b1;
              end else begin
                adc_en_q <= 1'b1;
                state_q  <= WARMUP;
              end
            end
          end

          WARMUP: begin
            if (APP_DATA_VALID) begin
              if (cnt_q == LEN_W'(WARMUP_SAMPLES - 1)) begin
                cnt_q   <= '0;
                phase_q <= '0;
                state_q <= (delay_q == '0) ? CAPTURE : BLANK;
              end else begin
                cnt_q <= cnt_q + LEN_W'(1);
              end
            end
          end

          BLANK: begin
            if (APP_DATA_VALID) begin
              if (cnt_q + LEN_W'(1) == delay_q) begin
                phase_q <= '0;
                state_q <= CAPTURE;
              end else begin
                cnt_q <= cnt_q + LEN_W'(1);
              end
            end
          end

          CAPTURE: begin
            if (APP_DATA_VALID) begin
              phase_q <= (phase_q == decim_q) ? '0 : phase_q + DECIM_W'(1);
              // Dropped kept samples still consume the window so it stays time-aligned.
              if (keep) begin
                remain_q <= remain_q - LEN_W'(1);
                if (keep_last) begin
                  adc_en_q <= 1'b0;
                  state_q  <= DRAIN;
                end
              end
            end
          end

          DRAIN: begin
            // A dropped LAST never transfers, so the window parks here until CMD_ABORT.
            if (last_accept) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ADC_EN    = adc_en_q;
  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign OVERFLOW  = ovf_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed scoreboard bench for adc_capture_ctrl driven by a ramping ADC model.
module tb_adc_capture_ctrl;
  import adc_ctrl_pkg::*;

  localparam int DATA_W  = 10;
  localparam int LEN_W   = 16;
  localparam int DECIM_W = 4;

  logic               SYS_CLK = 1'b0;
  logic               RESET;
  logic               CMD_START;
  logic               CMD_ABORT;
  logic [LEN_W-1:0]   CFG_DELAY;
  logic [LEN_W-1:0]   CFG_LENGTH;
  logic [DECIM_W-1:0] CFG_DECIM;
  logic [DATA_W-1:0]  APP_DATA;
  logic               APP_DATA_VALID;
  logic               ADC_EN;
  logic               BUSY;
  logic               DONE;
  logic               OVERFLOW;
  capture_state_t     DBG_STATE;

  adc_capture_ctrl_if #(.DATA_W(DATA_W)) out_if ();

  adc_capture_ctrl #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .DECIM_W(DECIM_W), .WARMUP_SAMPLES(4)
  ) dut (
    .SYS_CLK        (SYS_CLK),
    .RESET          (RESET),
    .CMD_START      (CMD_START),
    .CMD_ABORT      (CMD_ABORT),
    .CFG_DELAY      (CFG_DELAY),
    .CFG_LENGTH     (CFG_LENGTH),
    .CFG_DECIM      (CFG_DECIM),
    .APP_DATA       (APP_DATA),
    .APP_DATA_VALID (APP_DATA_VALID),
    .ADC_EN         (ADC_EN),
    .out_if         (out_if),
    .BUSY           (BUSY),
    .DONE           (DONE),
    .OVERFLOW       (OVERFLOW),
    .DBG_STATE      (DBG_STATE)
  );

  // ---------------- clock / watchdog ----------------
  always #10 SYS_CLK = ~SYS_CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q[$];
  int pass_cnt   = 0;
  int total_cnt  = 0;
  int beats_seen = 0;
  int done_cnt   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic start_window(input logic [LEN_W-1:0] d, input logic [LEN_W-1:0] l,
                              input logic [DECIM_W-1:0] m);
    CFG_DELAY  = d;
    CFG_LENGTH = l;
    CFG_DECIM  = m;
    CMD_START  = 1'b1;
    tick();
    CMD_START  = 1'b0;
  endtask

  task automatic abort_window();
    CMD_ABORT = 1'b1;
    tick();
    CMD_ABORT = 1'b0;
  endtask

  task automatic wait_state(input capture_state_t st, input int budget, input string name);
    int n = 0;
    while (DBG_STATE != st && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(DBG_STATE), 32'(st));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (BUSY && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(BUSY), 32'd0);
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (beats_seen < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(beats_seen), 32'(target));
  endtask

  task automatic run_basic(input string tag);
    int d0;
    d0 = done_cnt;
    out_if.OUT_READY = 1'b1;
    for (int i = 6; i <= 9; i++) push_exp(DATA_W'(i), (i == 9));
    start_window(16'd2, 16'd4, 4'd0);
    check({tag, "_adc_en_rise"}, 32'(ADC_EN), 32'd1);
    check({tag, "_busy"}, 32'(BUSY), 32'd1);
    check({tag, "_state_warmup"}, 32'(DBG_STATE), 32'(WARMUP));
    wait_idle(300, {tag, "_idle"});
    repeat (2) tick();
    check({tag, "_all_beats"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_adc_en_low"}, 32'(ADC_EN), 32'd0);
    check({tag, "_no_ovf"}, 32'(OVERFLOW), 32'd0);
  endtask

  // ---------------- ADC model: ramp on every 4th clock while enabled ----------------
  initial begin
    int div;
    logic [DATA_W-1:0] ramp;
    div = 0;
    ramp = '0;
    APP_DATA = '0;
    APP_DATA_VALID = 1'b0;
    forever begin
      tick();
      if (!ADC_EN) begin
        div = 0;
        ramp = '0;
        APP_DATA_VALID = 1'b0;
      end else begin
        div++;
        if (div == 4) begin
          div = 0;
          APP_DATA = ramp;
          APP_DATA_VALID = 1'b1;
          ramp = ramp + 1'b1;
        end else begin
          APP_DATA_VALID = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor: pops expected beats, checks DONE timing ----------------
  initial begin
    logic prev_last;
    logic zl_prev;
    logic exp_done;
    logic [DATA_W:0] exp_v;
    prev_last = 1'b0;
    zl_prev = 1'b0;
    forever begin
      @(negedge SYS_CLK);
      exp_done = prev_last | zl_prev;
      if (DONE || exp_done) check("done_pulse", 32'(DONE), 32'(exp_done));
      if (DONE) done_cnt++;
      zl_prev = CMD_START && (CFG_LENGTH == '0);
      prev_last = 1'b0;
      if (out_if.OUT_VALID && out_if.OUT_LAST)
        check("adc_en_low_with_last", 32'(ADC_EN), 32'd0);
      if (out_if.OUT_VALID && out_if.OUT_READY) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL beat_unexpected: got data %0d last %0d, expected no beat",
                   out_if.OUT_DATA, out_if.OUT_LAST);
        end else begin
          exp_v = exp_q.pop_front();
          check("beat_data", 32'(out_if.OUT_DATA), 32'(exp_v[DATA_W-1:0]));
          check("beat_last", 32'(out_if.OUT_LAST), 32'(exp_v[DATA_W]));
        end
        if (out_if.OUT_LAST) prev_last = 1'b1;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int d0;
    int b0;
    RESET = 1'b1;
    CMD_START = 1'b0;
    CMD_ABORT = 1'b0;
    CFG_DELAY = '0;
    CFG_LENGTH = '0;
    CFG_DECIM = '0;
    out_if.OUT_READY = 1'b1;
    repeat (3) tick();
    check("reset_adc_en", 32'(ADC_EN), 32'd0);
    check("reset_out_valid", 32'(out_if.OUT_VALID), 32'd0);
    check("reset_out_last", 32'(out_if.OUT_LAST), 32'd0);
    check("reset_out_data", 32'(out_if.OUT_DATA), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_ovf", 32'(OVERFLOW), 32'd0);
    check("reset_state", 32'(DBG_STATE), 32'(IDLE));
    RESET = 1'b0;
    repeat (2) tick();

    // Basic window: 6,7,8,9 with LAST on 9
    run_basic("basic");

    // Decimation: keep 1 of 3 starting at sample 4 -> 4,7,10
    d0 = done_cnt;
    push_exp(10'd4, 1'b0);
    push_exp(10'd7, 1'b0);
    push_exp(10'd10, 1'b1);
    start_window(16'd0, 16'd3, 4'd2);
    wait_idle(300, "decim_idle");
    repeat (2) tick();
    check("decim_all_beats", 32'(exp_q.size()), 32'd0);
    check("decim_one_done", 32'(done_cnt - d0), 32'd1);
    check("decim_no_ovf", 32'(OVERFLOW), 32'd0);

    // Backpressure: 4 held, 5 and 6 (LAST) dropped, window parks in DRAIN
    d0 = done_cnt;
    out_if.OUT_READY = 1'b0;
    push_exp(10'd4, 1'b0);
    start_window(16'd0, 16'd3, 4'd0);
    wait_state(DRAIN, 300, "bp_reach_drain");
    check("bp_ovf_set", 32'(OVERFLOW), 32'd1);
    check("bp_held_valid", 32'(out_if.OUT_VALID), 32'd1);
    check("bp_held_data", 32'(out_if.OUT_DATA), 32'd4);
    repeat (2) tick();
    out_if.OUT_READY = 1'b1;
    repeat (20) tick();
    check("bp_beats", 32'(exp_q.size()), 32'd0);
    check("bp_still_drain", 32'(DBG_STATE), 32'(DRAIN));
    check("bp_busy", 32'(BUSY), 32'd1);
    check("bp_no_done", 32'(done_cnt - d0), 32'd0);
    check("bp_adc_en_low", 32'(ADC_EN), 32'd0);
    abort_window();
    check("bp_abort_idle", 32'(DBG_STATE), 32'(IDLE));
    check("bp_ovf_retained", 32'(OVERFLOW), 32'd1);
    repeat (3) tick();
    check("bp_abort_no_done", 32'(done_cnt - d0), 32'd0);

    // Abort after two beats; a START mid-capture must be ignored
    d0 = done_cnt;
    b0 = beats_seen;
    push_exp(10'd4, 1'b0);
    push_exp(10'd5, 1'b0);
    start_window(16'd0, 16'd6, 4'd0);
    check("ab_ovf_cleared", 32'(OVERFLOW), 32'd0);
    wait_beats(b0 + 1, 300, "ab_first_beat");
    start_window(16'd5, 16'd1, 4'd3);
    check("ab_start_ignored", 32'(DBG_STATE), 32'(CAPTURE));
    wait_beats(b0 + 2, 100, "ab_second_beat");
    abort_window();
    check("ab_adc_en", 32'(ADC_EN), 32'd0);
    check("ab_out_valid", 32'(out_if.OUT_VALID), 32'd0);
    check("ab_busy", 32'(BUSY), 32'd0);
    repeat (8) tick();
    check("ab_beat_count", 32'(beats_seen - b0), 32'd2);
    check("ab_no_done", 32'(done_cnt - d0), 32'd0);

    // LENGTH=0: immediate DONE, ADC never enabled
    d0 = done_cnt;
    start_window(16'd3, 16'd0, 4'd1);
    check("zl_done", 32'(DONE), 32'd1);
    check("zl_adc_en", 32'(ADC_EN), 32'd0);
    check("zl_busy", 32'(BUSY), 32'd0);
    tick();
    check("zl_done_single", 32'(DONE), 32'd0);
    repeat (10) tick();
    check("zl_adc_en_stays_low", 32'(ADC_EN), 32'd0);
    check("zl_one_done", 32'(done_cnt - d0), 32'd1);

    // Reset during BLANK, then a normal window
    d0 = done_cnt;
    start_window(16'd5, 16'd4, 4'd0);
    wait_state(BLANK, 300, "rst_reach_blank");
    RESET = 1'b1;
    tick();
    check("rst_adc_en", 32'(ADC_EN), 32'd0);
    check("rst_out_valid", 32'(out_if.OUT_VALID), 32'd0);
    check("rst_out_data", 32'(out_if.OUT_DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_state", 32'(DBG_STATE), 32'(IDLE));
    RESET = 1'b0;
    repeat (3) tick();
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run_basic("post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
